// File: rtl/tlb_victim_ctrl.sv
// Replacement-victim controller for the shared L2 TLB: round-robin ITLB/DTLB refill arbitration, victim choice
// (free entry, LFSR probe, fallback). Define TLB_VICTIM_STATS_EN to add per-source grant statistics outputs.

module lfsr #(
  parameter int unsigned          LfsrWidth    = 16,
  parameter int unsigned          OutWidth     = 4,
  parameter logic [LfsrWidth-1:0] RstVal       = '1,
  parameter int unsigned          CipherLayers = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  output logic [OutWidth-1:0] out_o
);

  function automatic logic [63:0] bt(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  // Maximal-length Fibonacci tap sets; XOR feedback, so all-ones is a legal seed.
  function automatic logic [63:0] taps(input int unsigned w);
    logic [63:0] m;
    case (w)
      4:  m = bt(4) | bt(3);                          5:  m = bt(5) | bt(3);
      6:  m = bt(6) | bt(5);                          7:  m = bt(7) | bt(6);
      8:  m = bt(8) | bt(6) | bt(5) | bt(4);          9:  m = bt(9) | bt(5);
      10: m = bt(10) | bt(7);                         11: m = bt(11) | bt(9);
      12: m = bt(12) | bt(6) | bt(4) | bt(1);         13: m = bt(13) | bt(4) | bt(3) | bt(1);
      14: m = bt(14) | bt(5) | bt(3) | bt(1);         15: m = bt(15) | bt(14);
      16: m = bt(16) | bt(15) | bt(13) | bt(4);       17: m = bt(17) | bt(14);
      18: m = bt(18) | bt(11);                        19: m = bt(19) | bt(6) | bt(2) | bt(1);
      20: m = bt(20) | bt(17);                        21: m = bt(21) | bt(19);
      22: m = bt(22) | bt(21);                        23: m = bt(23) | bt(18);
      24: m = bt(24) | bt(23) | bt(22) | bt(17);      25: m = bt(25) | bt(22);
      26: m = bt(26) | bt(6) | bt(2) | bt(1);         27: m = bt(27) | bt(5) | bt(2) | bt(1);
      28: m = bt(28) | bt(25);                        29: m = bt(29) | bt(27);
      30: m = bt(30) | bt(6) | bt(4) | bt(1);         31: m = bt(31) | bt(28);
      32: m = bt(32) | bt(22) | bt(2) | bt(1);        33: m = bt(33) | bt(20);
      34: m = bt(34) | bt(27) | bt(2) | bt(1);        35: m = bt(35) | bt(33);
      36: m = bt(36) | bt(25);                        37: m = bt(37) | bt(5) | bt(4) | bt(3) | bt(2) | bt(1);
      38: m = bt(38) | bt(6) | bt(5) | bt(1);         39: m = bt(39) | bt(35);
      40: m = bt(40) | bt(38) | bt(21) | bt(19);      41: m = bt(41) | bt(38);
      42: m = bt(42) | bt(41) | bt(20) | bt(19);      43: m = bt(43) | bt(42) | bt(38) | bt(37);
      44: m = bt(44) | bt(43) | bt(18) | bt(17);      45: m = bt(45) | bt(44) | bt(42) | bt(41);
      46: m = bt(46) | bt(45) | bt(26) | bt(25);      47: m = bt(47) | bt(42);
      48: m = bt(48) | bt(47) | bt(21) | bt(20);      49: m = bt(49) | bt(40);
      50: m = bt(50) | bt(49) | bt(24) | bt(23);      51: m = bt(51) | bt(50) | bt(36) | bt(35);
      52: m = bt(52) | bt(49);                        53: m = bt(53) | bt(52) | bt(38) | bt(37);
      54: m = bt(54) | bt(53) | bt(18) | bt(17);      55: m = bt(55) | bt(31);
      56: m = bt(56) | bt(55) | bt(35) | bt(34);      57: m = bt(57) | bt(50);
      58: m = bt(58) | bt(39);                        59: m = bt(59) | bt(58) | bt(38) | bt(37);
      60: m = bt(60) | bt(59);                        61: m = bt(61) | bt(60) | bt(46) | bt(45);
      62: m = bt(62) | bt(61) | bt(6) | bt(5);        63: m = bt(63) | bt(62);
      default: m = bt(64) | bt(63) | bt(61) | bt(60);
    endcase
    return m;
  endfunction

  localparam logic [63:0]          TapsAll = taps(LfsrWidth);
  localparam logic [LfsrWidth-1:0] Taps    = TapsAll[LfsrWidth-1:0];

  logic [LfsrWidth-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[LfsrWidth-2:0], ^(state_q & Taps)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RstVal;
    else         state_q <= state_d;
  end

  if (CipherLayers == 0) begin : g_plain
    assign out_o = state_q[OutWidth-1:0];
  end else begin : g_cipher
    logic [LfsrWidth-1:0] rot;
    logic [OutWidth-1:0]  mix;
    always_comb begin
      rot = state_q;
      mix = state_q[OutWidth-1:0];
      for (int unsigned l = 0; l < CipherLayers; l++) begin
        rot = (rot >> OutWidth) | (rot << (LfsrWidth - OutWidth));
        mix = mix ^ rot[OutWidth-1:0];
      end
    end
    assign out_o = mix;
  end

endmodule

module tlb_victim_ctrl #(
  parameter int unsigned NumEntries = 16,
  parameter int unsigned LfsrWidth  = 16,
  parameter int unsigned MaxProbes  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NumEntries-1:0]         valid_i,
  input  logic [NumEntries-1:0]         lock_i,
  input  logic [1:0]                    req_i,
  output logic [1:0]                    gnt_o,
  output logic [$clog2(NumEntries)-1:0] victim_idx_o,
  output logic                          busy_o
`ifdef TLB_VICTIM_STATS_EN
  ,
  output logic [15:0]                   stat_free_o,
  output logic [15:0]                   stat_rand_o,
  output logic [15:0]                   stat_fallback_o
`endif
);

  localparam int unsigned IdxW   = $clog2(NumEntries);
  localparam logic [3:0]  MaxCnt = 4'(MaxProbes);

  typedef enum logic [1:0] {IDLE, SEL, GRANT} state_e;

  state_e          state_q;
  logic            prio_q, owner_q, busy_q;
  logic [3:0]      probe_cnt_q;
  logic [1:0]      gnt_q;
  logic [IdxW-1:0] victim_q, victim_idx_q;

  logic [IdxW-1:0]       rnd, free_idx, unlk_idx;
  logic [NumEntries-1:0] free;
  logic                  free_any, unlk_any, take_free, take_rand, take_fb;

  lfsr #(
    .LfsrWidth   (LfsrWidth),
    .OutWidth    (IdxW),
    .RstVal      ('1),
    .CipherLayers(0)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (state_q == SEL),
    .out_o (rnd)
  );

  always_comb begin
    free     = ~valid_i & ~lock_i;
    free_idx = '0;
    unlk_idx = '0;
    for (int unsigned i = NumEntries; i > 0; i--) begin
      if (free[i-1])    free_idx = IdxW'(i - 1);
      if (!lock_i[i-1]) unlk_idx = IdxW'(i - 1);
    end
  end

  assign free_any  = |free;
  assign unlk_any  = ~&lock_i;
  assign take_free = free_any;
  assign take_rand = !free_any && !lock_i[rnd];
  assign take_fb   = !free_any && lock_i[rnd] && (probe_cnt_q >= MaxCnt) && unlk_any;

  // The grant pulse is registered on leaving GRANT, so it is visible the cycle after GRANT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      probe_cnt_q  <= '0;
      gnt_q        <= '0;
      victim_q     <= '0;
      victim_idx_q <= '0;
    end else begin
      gnt_q <= '0;
      if (flush_i) begin
        state_q     <= IDLE;
        probe_cnt_q <= '0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (|req_i) begin
              owner_q <= req_i[prio_q] ? prio_q : ~prio_q;
              state_q <= SEL;
              busy_q  <= 1'b1;
            end
          end
          SEL: begin
            if (take_free) begin
              victim_q <= free_idx;
              state_q  <= GRANT;
            end else if (take_rand) begin
              victim_q <= rnd;
              state_q  <= GRANT;
            end else if (take_fb) begin
              victim_q <= unlk_idx;
              state_q  <= GRANT;
            end else if (probe_cnt_q != 4'hF) begin
              probe_cnt_q <= probe_cnt_q + 4'd1;
            end
          end
          GRANT: begin
            gnt_q[owner_q] <= 1'b1;
            victim_idx_q   <= victim_q;
            prio_q         <= ~owner_q;
            probe_cnt_q    <= '0;
            state_q        <= IDLE;
            busy_q         <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt_o        = gnt_q;
  assign victim_idx_o = victim_idx_q;
  assign busy_o       = busy_q;

`ifdef TLB_VICTIM_STATS_EN
  typedef enum logic [1:0] {SRC_FREE, SRC_RAND, SRC_FALLBACK} src_e;

  src_e        src_q;
  logic [15:0] stat_free_q, stat_rand_q, stat_fb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q       <= SRC_FREE;
      stat_free_q <= '0;
      stat_rand_q <= '0;
      stat_fb_q   <= '0;
    end else if (flush_i) begin
      stat_free_q <= '0;
      stat_rand_q <= '0;
      stat_fb_q   <= '0;
    end else if (state_q == SEL) begin
      if (take_free)      src_q <= SRC_FREE;
      else if (take_rand) src_q <= SRC_RAND;
      else if (take_fb)   src_q <= SRC_FALLBACK;
    end else if (state_q == GRANT) begin
      case (src_q)
        SRC_FREE:     if (stat_free_q != '1) stat_free_q <= stat_free_q + 16'd1;
        SRC_RAND:     if (stat_rand_q != '1) stat_rand_q <= stat_rand_q + 16'd1;
        SRC_FALLBACK: if (stat_fb_q != '1)   stat_fb_q   <= stat_fb_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign stat_free_o     = stat_free_q;
  assign stat_rand_o     = stat_rand_q;
  assign stat_fallback_o = stat_fb_q;
`endif

endmodule

// File: doc/tlb_victim_ctrl.md
# tlb_victim_ctrl

- Replacement-victim controller for the shared L2 TLB in the MMU.
- Arbitrates refill requests from the ITLB miss path (requester 0) and the DTLB miss path (requester 1), round-robin.
- Picks an entry index to overwrite: invalid entries first, then pseudo-random probes from an internal `lfsr` instance, then a deterministic fallback. Locked entries are never chosen.
- Returns the chosen index with a one-cycle grant pulse; sits between the PTW refill path and the shared TLB entry array.

## Interface
- `NumEntries`, 16: number of shared TLB entries; power of two, 2..64.
- `LfsrWidth`, 16: width of the internal LFSR; 4..64, and `LfsrWidth >= $clog2(NumEntries)`.
- `MaxProbes`, 4: random probes tried before falling back; 1..15.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset: asynchronous, active-low.
- `flush_i`  in  1  sfence/TLB flush; aborts any selection in progress.
- `valid_i`  in  NumEntries  per-entry valid bits from the TLB array.
- `lock_i`  in  NumEntries  per-entry lock bits (entry in use or pinned); a locked entry must never be chosen.
- `req_i`  in  2  refill request per requester; level-held until granted.
- `gnt_o`  out  2  one-hot grant pulse, one cycle.
- `victim_idx_o`  out  $clog2(NumEntries)  chosen entry; meaningful only while any `gnt_o` bit is high.
- `busy_o`  out  1  high in SEL and GRANT.

## Operation
- Random source: instance of `lfsr` with `LfsrWidth=LfsrWidth`, `OutWidth=$clog2(NumEntries)`, `RstVal='1`, `CipherLayers=0`.
  - `en_i` is high exactly in SEL cycles.
  - `rnd` is the `lfsr` output in the current cycle.
- FSM states: IDLE, SEL, GRANT.
- IDLE:
  - If any `req_i` bit is high, latch the owner and go to SEL.
  - Owner selection: round-robin pointer `prio` (reset 0). Grant `prio` if it is requesting, else the other requester.
- SEL, evaluated each cycle in this priority order:
  - (a) `free = ~valid_i & ~lock_i` is non-zero: victim = lowest set index of `free`; go to GRANT.
  - (b) `lock_i[rnd]` is 0: victim = `rnd`; go to GRANT.
  - (c) Otherwise increment `probe_cnt` (4 bits, saturating).
    - When the count reaches `MaxProbes`, victim = lowest index with `lock_i` clear, then go to GRANT.
    - If every entry is locked, stay in SEL and keep advancing the LFSR until an entry unlocks.
- GRANT:
  - `gnt_o[owner]=1` and `victim_idx_o`=victim for one cycle.
  - `prio` becomes `~owner`, `probe_cnt` clears, go to IDLE.
- `victim_idx_o` holds its last value outside GRANT.
- `flush_i` in any state:
  - Next state is IDLE, `probe_cnt` clears, no grant is issued.
  - `prio` and the LFSR state are kept.
  - The aborted requester re-requests and re-arbitrates normally.
- `req_i[owner]` dropping before grant is a protocol violation; behaviour is unchanged.
- `valid_i` and `lock_i` are sampled combinationally every SEL cycle; no snapshot is taken.

## Timing
- Reset values:
  - `gnt_o=0`, `victim_idx_o=0`, `busy_o=0`.
  - State IDLE, `prio=0`, `probe_cnt=0`; LFSR state all ones.
- Request-to-grant latency: `req_i` sampled high at edge t gives `gnt_o` high in the cycle after edge t+2 (min 2 cycles).
  - Each failed probe adds 1 cycle.
  - Worst case without a full lock is 2+`MaxProbes` cycles.
- Back-to-back requests: one grant at most every 3 cycles (IDLE, SEL, GRANT).
- Both requesters high in the same cycle: `prio` wins; the other is granted in the next transaction.
- The LFSR advances once per SEL cycle, including cycles resolved by (a).
- Reset mid-operation returns everything to reset values immediately (asynchronous).

## Configuration
- `TLB_VICTIM_STATS_EN` defined: adds outputs `stat_free_o`, `stat_rand_o`, `stat_fallback_o`.
  - Each is 16 bits, saturating, reset 0.
  - Each increments on a grant resolved by (a), (b) or (c) respectively; cleared by `flush_i`.
- Not defined: these ports and counters do not exist; grant behaviour is identical.

## Test plan
- `NumEntries=16`, all valid, none locked, first `req_i=01` after reset -> `gnt_o=01` after 2 cycles, `victim_idx_o=15` (LFSR all-ones state).
- Entries 3 and 9 invalid and unlocked, `req_i=10` -> victim 3, 2-cycle latency.
- `req_i=11` held -> grants 01 then 10; the next `req_i=11` grants 01 again (round-robin).
- All valid; every entry except 5 locked; `MaxProbes=4`; no LFSR probe hits 5 -> grant after 6 cycles with victim 5.
- All entries locked for 10 cycles, then `lock_i[7]` cleared -> no grant while fully locked; afterwards victim 7; `busy_o` high throughout.
- `flush_i` pulsed in SEL -> no grant, IDLE next cycle; with `TLB_VICTIM_STATS_EN`, counters read 0.
